// File: rtl/redundant_limb_normalizer.sv
// Resolves signed redundant limbs into a flat two's-complement integer,
// one limb per cycle from least to most significant, with a signed carry.
module redundant_limb_normalizer #(
  parameter int unsigned NUM_LIMBS = 35,
  parameter int unsigned BIT_LEN   = 17,
  parameter int unsigned WORD_LEN  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [NUM_LIMBS*(BIT_LEN+1)-1:0]       in_limbs,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [WORD_LEN*NUM_LIMBS+1:0]   out_value,
  output logic                                   out_ovf
);

  localparam int unsigned LIMB_W  = BIT_LEN + 1;
  localparam int unsigned SUM_W   = BIT_LEN + 2;
  localparam int unsigned CARRY_W = SUM_W - WORD_LEN;
  localparam int unsigned OUT_W   = WORD_LEN * NUM_LIMBS + 2;
  localparam int unsigned IDX_W   = $clog2(NUM_LIMBS);

  localparam logic signed [CARRY_W-1:0] CARRY_MIN = CARRY_W'(-2);
  localparam logic signed [CARRY_W-1:0] CARRY_MAX = CARRY_W'(1);
  localparam logic [IDX_W-1:0]          IDX_LAST  = IDX_W'(NUM_LIMBS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state, state_next;
  logic [LIMB_W-1:0]          limbs [NUM_LIMBS];
  logic [IDX_W-1:0]           idx;
  logic signed [CARRY_W-1:0]  carry;
  logic [LIMB_W-1:0]          limb_cur;
  logic signed [SUM_W-1:0]    sum;
  logic                       load, step, finalize, drop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_next = RUN;
      RUN:     if (idx == IDX_LAST)      state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath controls; DONE spends its first cycle folding the final carry in
  always_comb begin
    load     = 1'b0;
    step     = 1'b0;
    finalize = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE:    load     = in_valid && in_ready;
      RUN:     step     = 1'b1;
      DONE: begin
        finalize = !out_valid;
        drop     = out_valid && out_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    limb_cur = limbs[idx];
    sum      = SUM_W'($signed(limb_cur)) + SUM_W'(carry);
  end

  // Local copy of the operand so the producer may move on after accept
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < int'(NUM_LIMBS); i++)
        limbs[i] <= in_limbs[i*LIMB_W +: LIMB_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_ovf   <= 1'b0;
      idx       <= '0;
      carry     <= '0;
    end else begin
      in_ready <= (state_next == IDLE);
      if (load) begin
        idx   <= '0;
        carry <= '0;
      end
      if (step) begin
        out_value[32'(idx)*WORD_LEN +: WORD_LEN] <= sum[WORD_LEN-1:0];
        carry <= sum[SUM_W-1:WORD_LEN];
        idx   <= idx + IDX_W'(1);
      end
      // Final carry becomes the two sign bits; anything outside [-2,1] is lost
      if (finalize) begin
        out_value[OUT_W-1 -: 2] <= carry[1:0];
        out_ovf   <= (carry < CARRY_MIN) || (carry > CARRY_MAX);
        out_valid <= 1'b1;
      end
      if (drop) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_redundant_limb_normalizer.sv
// Directed and random checks of redundant_limb_normalizer against a wide
// integer model of sum(limb[i] * 2^(16*i)).
module tb_redundant_limb_normalizer;

  localparam int NL = 35;
  localparam int LW = 18;
  localparam int VW = NL * LW;
  localparam int OW = 16 * NL + 2;
  localparam int MW = 600;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_limbs;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_value;
  logic          out_ovf;

  int vectors = 0;
  int miscompares = 0;

  redundant_limb_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_limbs  (in_limbs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic signed [MW-1:0] model(input logic [VW-1:0] v);
    logic signed [MW-1:0] acc;
    logic signed [LW-1:0] l;
    acc = '0;
    for (int i = 0; i < NL; i++) begin
      l   = v[i*LW +: LW];
      acc = acc + (MW'(l) <<< (16 * i));
    end
    return acc;
  endfunction

  function automatic logic model_ovf(input logic signed [MW-1:0] w);
    logic signed [OW-1:0] t;
    t = w[OW-1:0];
    return (MW'(t) !== w);
  endfunction

  function automatic logic [VW-1:0] fill(input logic [LW-1:0] l);
    logic [VW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*LW +: LW] = l;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand and wait for the result; out_ready optionally random during RUN
  task automatic drive_txn(input logic [VW-1:0] v, input bit rnd_ready,
                           output logic [OW-1:0] val, output logic ovf, output int lat);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin tick(); t++; end
    in_valid = 1'b1;
    in_limbs = v;
    tick();
    in_valid = 1'b0;
    in_limbs = ~v;
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    out_ready = 1'b0;
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL txn_timeout: out_valid=%b after %0d cycles, want 1", out_valid, lat);
    end
    val = out_value;
    ovf = out_ovf;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_limbs = '0;
    tick(); tick();
    vectors++;
    if ({in_ready, out_valid, out_ovf} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: in_ready/out_valid/out_ovf=%b, want 000", {in_ready, out_valid, out_ovf});
    end
    vectors++;
    if (out_value !== '0) begin
      miscompares++;
      $display("FAIL reset_value: got %h, want 0", out_value);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_idle_ready: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_zero();
    logic [OW-1:0] val; logic ovf; int lat;
    drive_txn('0, 1'b0, val, ovf, lat);
    vectors++;
    if (lat !== 36) begin
      miscompares++;
      $display("FAIL zero_latency: got %0d, want 36", lat);
    end
    vectors++;
    if ({ovf, val} !== {1'b0, {OW{1'b0}}}) begin
      miscompares++;
      $display("FAIL zero_value: ovf=%b val=%h, want ovf=0 val=0", ovf, val);
    end
    release_out();
  endtask

  task automatic test_single_limb();
    logic [OW-1:0] val, exp; logic ovf; int lat; logic [VW-1:0] v;
    v = '0; v[LW-1:0] = '1;
    drive_txn(v, 1'b0, val, ovf, lat);
    exp = '1;
    vectors++;
    if ({ovf, val} !== {1'b0, exp}) begin
      miscompares++;
      $display("FAIL minus_one: ovf=%b val=%h, want ovf=0 val=%h", ovf, val, exp);
    end
    release_out();
    v = '0; v[LW-1:0] = 18'd131071;
    drive_txn(v, 1'b0, val, ovf, lat);
    exp = '0; exp[15:0] = 16'hFFFF; exp[31:16] = 16'h0001;
    vectors++;
    if ({ovf, val} !== {1'b0, exp}) begin
      miscompares++;
      $display("FAIL max_limb0: ovf=%b val=%h, want ovf=0 val=%h", ovf, val, exp);
    end
    release_out();
  endtask

  task automatic test_carry_chain();
    logic [OW-1:0] val, exp; logic ovf; int lat; logic signed [MW-1:0] w;
    drive_txn(fill(18'd65536), 1'b0, val, ovf, lat);
    exp = '0;
    for (int i = 1; i < NL; i++) exp[16*i +: 16] = 16'h0001;
    exp[OW-1 -: 2] = 2'b01;
    vectors++;
    if ({ovf, val} !== {1'b0, exp}) begin
      miscompares++;
      $display("FAIL all_65536: ovf=%b val=%h, want ovf=0 val=%h", ovf, val, exp);
    end
    release_out();
    w = model(fill(18'h20000));
    drive_txn(fill(18'h20000), 1'b0, val, ovf, lat);
    vectors++;
    if (val !== w[OW-1:0]) begin
      miscompares++;
      $display("FAIL all_min_value: got %h, want %h", val, w[OW-1:0]);
    end
    vectors++;
    if (ovf !== model_ovf(w)) begin
      miscompares++;
      $display("FAIL all_min_ovf: got %b, want %b", ovf, model_ovf(w));
    end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] val; logic ovf; int lat; logic [VW-1:0] v;
    v = '0; v[LW-1:0] = 18'd131071;
    drive_txn(v, 1'b0, val, ovf, lat);
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if ({out_valid, in_ready, out_value} !== {1'b1, 1'b0, val}) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: valid=%b ready=%b val=%h, want 1 0 %h", c, out_valid, in_ready, out_value, val);
      end
    end
    release_out();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL release: out_valid/in_ready=%b, want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_abort();
    logic [OW-1:0] val; logic ovf; int lat;
    in_valid = 1'b1;
    in_limbs = fill('1);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL abort_idle: out_valid/in_ready=%b, want 01", {out_valid, in_ready});
    end
    repeat (30) tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_pulse: out_valid=%b, want 0", out_valid);
    end
    drive_txn('0, 1'b0, val, ovf, lat);
    vectors++;
    if ({ovf, val, lat} !== {1'b0, {OW{1'b0}}, 32'd36}) begin
      miscompares++;
      $display("FAIL abort_recover: ovf=%b lat=%0d val=%h, want 0 36 0", ovf, lat, val);
    end
    release_out();
  endtask

  task automatic test_random();
    logic [OW-1:0] val; logic ovf; int lat; logic [VW-1:0] v; logic signed [MW-1:0] w;
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < NL; i++) v[i*LW +: LW] = LW'($urandom());
      w = model(v);
      drive_txn(v, 1'b1, val, ovf, lat);
      vectors++;
      if ({ovf, val} !== {model_ovf(w), w[OW-1:0]}) begin
        miscompares++;
        $display("FAIL rand%0d: ovf=%b val=%h, want ovf=%b val=%h", n, ovf, val, model_ovf(w), w[OW-1:0]);
      end
      repeat ($urandom_range(0, 3)) tick();
      release_out();
    end
    // 131071 everywhere drives the carry to 2 into and out of the top limb
    w = model(fill(18'd131071));
    drive_txn(fill(18'd131071), 1'b0, val, ovf, lat);
    vectors++;
    if (ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL forced_ovf: got %b, want 1", ovf);
    end
    vectors++;
    if (val !== w[OW-1:0]) begin
      miscompares++;
      $display("FAIL forced_ovf_value: got %h, want %h", val, w[OW-1:0]);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_single_limb();
    test_carry_chain();
    test_backpressure();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
